line_peak_detector: RTL and testbench
=====================================

Name: line_peak_detector

Overview:
- Measures the brightest pixel of each sensor line inside a configurable window.
- Presents that peak as an 8-bit value with a one-cycle update strobe, ready to drive the AGC gain stepper (its update/data_in inputs).
- Sits between the sensor pixel stream and the AGC. It skips a configurable number of lines after each report so that a gain step can settle before the next measurement.

Parameters:
- LINE_LEN, 1024, pixels per line (≥ 2).
- WIN_START, 0, first pixel index included in the peak search.
- WIN_END, 1024, first pixel index excluded from the search. Must satisfy WIN_START < WIN_END ≤ LINE_LEN.
- SKIP_LINES, 1, whole lines ignored after each report (0 = measure every line).
- CNT_W, 11, pixel counter width. Must hold LINE_LEN-1.

Ports:
- clk_in, in, 1, system clock; all logic on the rising edge.
- rst_n, in, 1, reset; synchronous, active-low.
- line_start, in, 1, one-cycle pulse marking the start of a sensor line.
- pix_valid, in, 1, pix_data is a valid pixel this cycle.
- pix_data, in, 8, pixel amplitude.
- peak, out, 8, latched line peak, held between updates.
- update, out, 1, one-cycle strobe; peak is new in the same cycle.
- busy, out, 1, high in the ACTIVE state.
- abort, out, 1, one-cycle pulse when a line is restarted before completion.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; pix_cnt=0; run_max=0; skip_cnt=0.
  - peak=0, update=0, busy=0, abort=0.
  - Reset mid-line discards the partial measurement with no update.
- States:
  - IDLE: pix_valid ignored. line_start → ACTIVE, with pix_cnt=0 and run_max=0.
  - ACTIVE:
    - Each cycle with pix_valid=1: if WIN_START ≤ pix_cnt < WIN_END and pix_data > run_max, then run_max ← pix_data. pix_cnt increments.
    - Pixel on a line_start cycle: not counted. Counting begins the cycle after line_start.
    - Last pixel (pix_valid=1 and pix_cnt==LINE_LEN-1):
      - The search includes this pixel.
      - At that edge: peak ← final max, update ← 1 for exactly one cycle (latency 1 clock after the last pixel is sampled), skip_cnt ← 0.
      - Next state: SKIP if SKIP_LINES>0, else IDLE.
    - line_start in ACTIVE before the last pixel: abort=1 for one cycle; pix_cnt=0; run_max=0; remain ACTIVE. No update; peak unchanged.
    - line_start on the same cycle as the last pixel: the last pixel completes the line (update=1, no abort), and that line_start is then handled by the next state's rules.
  - SKIP:
    - Each line_start increments skip_cnt.
    - A line_start that arrives with skip_cnt==SKIP_LINES enters ACTIVE (cleared as from IDLE) instead of incrementing.
    - pix_valid ignored.
- Outputs:
  - busy = (state==ACTIVE), registered.
  - peak changes only on update cycles.
  - update and abort never assert in the same cycle.
- Arithmetic:
  - Compares are unsigned 8-bit.
  - pix_cnt never exceeds LINE_LEN-1; it does not wrap past that.
  - Extra pix_valid pulses arriving after the last pixel fall into SKIP/IDLE and are ignored.
- Empty window: a line whose windowed pixels are all 0 reports peak=0.

Optional Feature:
- Macro: LINE_PEAK_SAT_COUNT_EN.
- Defined:
  - Adds parameter SAT_LEVEL (default 250) and output sat_cnt [CNT_W-1:0].
  - Counts in-window pixels with pix_data ≥ SAT_LEVEL, saturating at all ones.
  - Latched into sat_cnt on update; reset value 0; cleared with run_max on line start and on abort.
- Undefined: no sat_cnt port and no counter logic; all other behaviour identical.

Test Plan:
- Reset, then LINE_LEN=16, window 0..16, SKIP_LINES=0, ramp 0..15 → update one clock after pixel 15; peak=15; busy falls the same cycle.
- Window 4..8, pixels 200 at index 2 and 90 at index 5, others 10 → peak=90; the out-of-window 200 is ignored.
- SKIP_LINES=2, four lines each with peak 100 → updates on lines 1 and 4 only; lines 2–3 produce no update.
- line_start at pixel 7 of a line with running max 180, next line max 50 → abort pulse at the restart; a single update with peak=50.
- rst_n low at pixel 10, then a full line with max 33 → no update before reset; after reset, peak=0 until update shows 33.
- With LINE_PEAK_SAT_COUNT_EN, line containing 3 pixels ≥250 in window and 1 out of window → sat_cnt=3 on update.

Source files
------------

// File: rtl/line_peak_detector.sv
// Line peak detector: finds the largest windowed pixel of each sensor line and reports it with a
// one-cycle update strobe, skipping SKIP_LINES lines after each report. Optional saturation counter:
// define LINE_PEAK_SAT_COUNT_EN.
module line_peak_detector #(
  parameter int LINE_LEN   = 1024,
  parameter int WIN_START  = 0,
  parameter int WIN_END    = 1024,
  parameter int SKIP_LINES = 1,
  parameter int CNT_W      = 11
`ifdef LINE_PEAK_SAT_COUNT_EN
  ,
  parameter int SAT_LEVEL  = 250
`endif
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             line_start,
  input  logic             pix_valid,
  input  logic [7:0]       pix_data,
  output logic [7:0]       peak,
  output logic             update,
  output logic             busy,
  output logic             abort
`ifdef LINE_PEAK_SAT_COUNT_EN
  ,
  output logic [CNT_W-1:0] sat_cnt
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, SKIP = 2'd2} state_t;

  localparam int               SKIP_W   = (SKIP_LINES > 0) ? $clog2(SKIP_LINES + 1) : 1;
  localparam bit               HAS_SKIP = (SKIP_LINES > 0);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_LEN - 1);
  localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(SKIP_LINES);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  pix_cnt_reg, pix_cnt_next;
  logic [7:0]        run_max_reg, run_max_next;
  logic [SKIP_W-1:0] skip_cnt_reg, skip_cnt_next;
  logic [7:0]        peak_reg, peak_next;
  logic              update_reg, update_next;
  logic              busy_reg, busy_next;
  logic              abort_reg, abort_next;
  logic              clear_line;

  logic       win_lo_ok, win_hi_ok, in_window;
  logic       last_pix;
  logic [7:0] max_cand;

  // Window bounds that coincide with the line edges are always satisfied.
  generate
    if (WIN_START == 0) begin : g_lo_open
      assign win_lo_ok = 1'b1;
    end else begin : g_lo_cmp
      assign win_lo_ok = (int'(pix_cnt_reg) >= WIN_START);
    end
    if (WIN_END >= LINE_LEN) begin : g_hi_open
      assign win_hi_ok = 1'b1;
    end else begin : g_hi_cmp
      assign win_hi_ok = (int'(pix_cnt_reg) < WIN_END);
    end
  endgenerate

  assign in_window = win_lo_ok && win_hi_ok;
  assign last_pix  = (state_reg == ACTIVE) && pix_valid && (pix_cnt_reg == LAST_IDX);
  assign max_cand  = (pix_valid && in_window && (pix_data > run_max_reg)) ? pix_data : run_max_reg;

`ifdef LINE_PEAK_SAT_COUNT_EN
  logic [CNT_W-1:0] sat_run_reg, sat_run_next;
  logic [CNT_W-1:0] sat_cnt_reg, sat_cnt_next;
  logic [CNT_W-1:0] sat_cand;

  assign sat_cand = (pix_valid && in_window && (int'(pix_data) >= SAT_LEVEL) && (sat_run_reg != '1))
                    ? sat_run_reg + CNT_W'(1) : sat_run_reg;
  assign sat_cnt  = sat_cnt_reg;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (line_start) state_next = ACTIVE;
      end
      ACTIVE: begin
        // A line_start coinciding with the last pixel is handed to the following state.
        if (last_pix) state_next = HAS_SKIP ? SKIP : (line_start ? ACTIVE : IDLE);
      end
      SKIP: begin
        if (line_start && (skip_cnt_reg == SKIP_MAX)) state_next = ACTIVE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pix_cnt_next  = pix_cnt_reg;
    run_max_next  = run_max_reg;
    skip_cnt_next = skip_cnt_reg;
    peak_next     = peak_reg;
    update_next   = 1'b0;
    abort_next    = 1'b0;
    busy_next     = (state_next == ACTIVE);
    clear_line    = 1'b0;
`ifdef LINE_PEAK_SAT_COUNT_EN
    sat_run_next  = sat_run_reg;
    sat_cnt_next  = sat_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (line_start) clear_line = 1'b1;
      end
      ACTIVE: begin
        if (last_pix) begin
          peak_next     = max_cand;
          update_next   = 1'b1;
          skip_cnt_next = '0;
          clear_line    = 1'b1;
`ifdef LINE_PEAK_SAT_COUNT_EN
          sat_cnt_next  = sat_cand;
`endif
          if (line_start && HAS_SKIP) skip_cnt_next = SKIP_W'(1);
        end else if (line_start) begin
          abort_next = 1'b1;
          clear_line = 1'b1;
        end else if (pix_valid) begin
          pix_cnt_next = pix_cnt_reg + CNT_W'(1);
          run_max_next = max_cand;
`ifdef LINE_PEAK_SAT_COUNT_EN
          sat_run_next = sat_cand;
`endif
        end
      end
      SKIP: begin
        if (line_start) begin
          if (skip_cnt_reg == SKIP_MAX) clear_line = 1'b1;
          else skip_cnt_next = skip_cnt_reg + SKIP_W'(1);
        end
      end
      default: ;
    endcase
    if (clear_line) begin
      pix_cnt_next = '0;
      run_max_next = '0;
`ifdef LINE_PEAK_SAT_COUNT_EN
      sat_run_next = '0;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      pix_cnt_reg  <= '0;
      run_max_reg  <= '0;
      skip_cnt_reg <= '0;
      peak_reg     <= '0;
      update_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      abort_reg    <= 1'b0;
`ifdef LINE_PEAK_SAT_COUNT_EN
      sat_run_reg  <= '0;
      sat_cnt_reg  <= '0;
`endif
    end else begin
      pix_cnt_reg  <= pix_cnt_next;
      run_max_reg  <= run_max_next;
      skip_cnt_reg <= skip_cnt_next;
      peak_reg     <= peak_next;
      update_reg   <= update_next;
      busy_reg     <= busy_next;
      abort_reg    <= abort_next;
`ifdef LINE_PEAK_SAT_COUNT_EN
      sat_run_reg  <= sat_run_next;
      sat_cnt_reg  <= sat_cnt_next;
`endif
    end
  end

  assign peak   = peak_reg;
  assign update = update_reg;
  assign busy   = busy_reg;
  assign abort  = abort_reg;

endmodule

// File: tb/tb_line_peak_detector.sv
// Scoreboard bench for line_peak_detector: three 16-pixel instances (full window, window 4..8,
// SKIP_LINES=2); a negedge monitor checks updates, aborts and sampled state against queued expectations.
module tb_line_peak_detector;

  localparam int K_PEAK = 0, K_BUSY = 1, K_UPD = 2, K_ABT = 3, K_SAT = 4;

  typedef struct {
    int cyc;
    int pk;
    int sat;
    int bsy;
  } exp_t;

  typedef struct {
    int cyc;
    int d;
    int kind;
    int val;
  } smp_t;

  logic       clk_in = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] ls;
  logic [2:0] pv;
  logic [7:0] pd  [3];
  logic [7:0] pk  [3];
  logic       upd [3];
  logic       bsy [3];
  logic       abt [3];
`ifdef LINE_PEAK_SAT_COUNT_EN
  logic [3:0] sc  [3];
`endif

  int   cyc = 0;
  int   vec_cnt = 0;
  int   miss_cnt = 0;
  exp_t uq [3][$];
  int   aq [3][$];
  smp_t sq [$];
  logic [7:0] px_buf [16];

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    line_peak_detector #(
      .LINE_LEN  (16),
      .WIN_START (gi == 1 ? 4 : 0),
      .WIN_END   (gi == 1 ? 8 : 16),
      .SKIP_LINES(gi == 2 ? 2 : 0),
      .CNT_W     (4)
    ) u_dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n[gi]),
      .line_start(ls[gi]),
      .pix_valid (pv[gi]),
      .pix_data  (pd[gi]),
      .peak      (pk[gi]),
      .update    (upd[gi]),
      .busy      (bsy[gi]),
      .abort     (abt[gi])
`ifdef LINE_PEAK_SAT_COUNT_EN
      ,
      .sat_cnt   (sc[gi])
`endif
    );
  end

  // Monitor: consumes the expectation queues whenever the DUTs present something.
  always @(negedge clk_in) begin
    exp_t e;
    smp_t s;
    int   act;
    int   act_sat;
    for (int d = 0; d < 3; d++) begin
      while (uq[d].size() > 0 && uq[d][0].cyc < cyc) begin
        e = uq[d].pop_front();
        vec_cnt++; miss_cnt++;
        $display("FAIL upd%0d_missing: no update seen, required peak=%0d at cycle %0d", d, e.pk, e.cyc);
      end
      while (aq[d].size() > 0 && aq[d][0] < cyc) begin
        act = aq[d].pop_front();
        vec_cnt++; miss_cnt++;
        $display("FAIL abort%0d_missing: no abort seen, required at cycle %0d", d, act);
      end
      if (upd[d] && abt[d]) begin
        vec_cnt++; miss_cnt++;
        $display("FAIL upd_abort%0d: update and abort both high at cycle %0d, required exclusive", d, cyc);
      end
      if (upd[d]) begin
        vec_cnt++;
        act_sat = 0;
`ifdef LINE_PEAK_SAT_COUNT_EN
        act_sat = int'(sc[d]);
`endif
        if (uq[d].size() == 0) begin
          miss_cnt++;
          $display("FAIL upd%0d_unexpected: update at cycle %0d peak=%0d, required none", d, cyc, pk[d]);
        end else begin
          e = uq[d].pop_front();
`ifndef LINE_PEAK_SAT_COUNT_EN
          e.sat = 0;
`endif
          if (e.cyc != cyc || int'(pk[d]) != e.pk || int'(bsy[d]) != e.bsy || act_sat != e.sat) begin
            miss_cnt++;
            $display("FAIL upd%0d: got cyc=%0d peak=%0d busy=%0d sat=%0d, required cyc=%0d peak=%0d busy=%0d sat=%0d",
                     d, cyc, pk[d], bsy[d], act_sat, e.cyc, e.pk, e.bsy, e.sat);
          end else begin
            $display("update inst=%0d cyc=%0d peak=%0d sat=%0d ok", d, cyc, pk[d], act_sat);
          end
        end
      end
      if (abt[d]) begin
        vec_cnt++;
        if (aq[d].size() == 0) begin
          miss_cnt++;
          $display("FAIL abort%0d_unexpected: abort at cycle %0d, required none", d, cyc);
        end else begin
          act = aq[d].pop_front();
          if (act != cyc) begin
            miss_cnt++;
            $display("FAIL abort%0d: got cycle %0d, required cycle %0d", d, cyc, act);
          end else begin
            $display("abort inst=%0d cyc=%0d ok", d, cyc);
          end
        end
      end
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      s = sq.pop_front();
      act = -1;
      case (s.kind)
        K_PEAK: act = int'(pk[s.d]);
        K_BUSY: act = int'(bsy[s.d]);
        K_UPD:  act = int'(upd[s.d]);
        K_ABT:  act = int'(abt[s.d]);
`ifdef LINE_PEAK_SAT_COUNT_EN
        K_SAT:  act = int'(sc[s.d]);
`endif
        default: act = -1;
      endcase
      vec_cnt++;
      if (s.cyc != cyc || act != s.val) begin
        miss_cnt++;
        $display("FAIL sample%0d_k%0d: got %0d at cycle %0d, required %0d at cycle %0d",
                 s.d, s.kind, act, cyc, s.val, s.cyc);
      end else begin
        $display("sample inst=%0d kind=%0d cyc=%0d value=%0d ok", s.d, s.kind, cyc, act);
      end
    end
  end

  task automatic step(input int d, input logic l, input logic v, input logic [7:0] x);
    ls[d] = l;
    pv[d] = v;
    pd[d] = x;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    ls = '0;
    pv = '0;
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic expect_now(input int d, input int kind, input int val);
    sq.push_back('{cyc, d, kind, val});
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) px_buf[i] = v;
  endtask

  // Sends 16 pixels from px_buf; optionally preceded by line_start and/or with line_start on pixel 15.
  task automatic send_line(input int d, input bit do_start, input bit ls_last, input int exp_busy,
                           input bit exp_upd, input int epk, input int esat, input int busy_after);
    if (do_start) step(d, 1'b1, 1'b0, 8'h00);
    expect_now(d, K_BUSY, exp_busy);
    for (int i = 0; i < 16; i++) begin
      if (i == 15 && exp_upd) uq[d].push_back('{cyc + 1, epk, esat, busy_after});
      step(d, (i == 15) ? ls_last : 1'b0, 1'b1, px_buf[i]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = '0;
    ls    = '0;
    pv    = '0;
    for (int d = 0; d < 3; d++) pd[d] = 8'h00;
    repeat (3) begin
      @(posedge clk_in);
      #1;
    end
    rst_n = '1;
    for (int d = 0; d < 3; d++) begin
      expect_now(d, K_PEAK, 0);
      expect_now(d, K_UPD, 0);
      expect_now(d, K_BUSY, 0);
      expect_now(d, K_ABT, 0);
`ifdef LINE_PEAK_SAT_COUNT_EN
      expect_now(d, K_SAT, 0);
`endif
    end
    idle(2);

    // Instance 0: ramp, peak 15, busy drops with the update
    for (int i = 0; i < 16; i++) px_buf[i] = 8'(i);
    send_line(0, 1'b1, 1'b0, 1, 1'b1, 15, 0, 0);
    idle(2);

    // line_start on the last pixel: report 77 and go straight back to ACTIVE
    fill(8'd3); px_buf[6] = 8'd77;
    send_line(0, 1'b1, 1'b1, 1, 1'b1, 77, 0, 1);
    fill(8'd2); px_buf[11] = 8'd5;
    send_line(0, 1'b0, 1'b0, 1, 1'b1, 5, 0, 0);
    idle(2);

    // Restart at pixel 7 with running max 180; next line max 50
    step(0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) step(0, 1'b0, 1'b1, (i == 3) ? 8'd180 : 8'd20);
    aq[0].push_back(cyc + 1);
    step(0, 1'b1, 1'b1, 8'd99);
    expect_now(0, K_PEAK, 5);
    expect_now(0, K_UPD, 0);
    for (int i = 0; i < 16; i++) px_buf[i] = 8'(i);
    px_buf[9] = 8'd50;
    send_line(0, 1'b0, 1'b0, 1, 1'b1, 50, 0, 0);
    idle(2);

    // Reset at pixel 10 discards the line; peak returns to 0
    step(0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 10; i++) step(0, 1'b0, 1'b1, (i == 2) ? 8'd200 : 8'd1);
    rst_n[0] = 1'b0;
    step(0, 1'b0, 1'b1, 8'd7);
    rst_n[0] = 1'b1;
    expect_now(0, K_PEAK, 0);
    expect_now(0, K_BUSY, 0);
    expect_now(0, K_UPD, 0);
    idle(2);
    expect_now(0, K_PEAK, 0);
    for (int i = 0; i < 16; i++) px_buf[i] = 8'(i % 4);
    px_buf[0] = 8'd33;
    send_line(0, 1'b1, 1'b0, 1, 1'b1, 33, 0, 0);
    // Stray pixels after the line must be ignored
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 8'd255);
    expect_now(0, K_PEAK, 33);
    expect_now(0, K_BUSY, 0);
    idle(2);

    // Instance 1: window 4..8
    fill(8'd10); px_buf[2] = 8'd200; px_buf[5] = 8'd90;
    send_line(1, 1'b1, 1'b0, 1, 1'b1, 90, 0, 0);
    idle(1);
    fill(8'd5); px_buf[3] = 8'd140; px_buf[4] = 8'd60; px_buf[7] = 8'd120; px_buf[8] = 8'd150;
    send_line(1, 1'b1, 1'b0, 1, 1'b1, 120, 0, 0);
    idle(1);
    fill(8'd255);
    for (int i = 4; i < 8; i++) px_buf[i] = 8'd0;
    send_line(1, 1'b1, 1'b0, 1, 1'b1, 0, 0, 0);
    idle(1);
`ifdef LINE_PEAK_SAT_COUNT_EN
    fill(8'd1);
    px_buf[4] = 8'd250; px_buf[5] = 8'd255; px_buf[6] = 8'd249; px_buf[7] = 8'd251; px_buf[10] = 8'd255;
    send_line(1, 1'b1, 1'b0, 1, 1'b1, 255, 3, 0);
    idle(1);
`endif

    // Instance 2: SKIP_LINES=2, updates only on lines 1 and 4
    fill(8'd1); px_buf[7] = 8'd100;
    send_line(2, 1'b1, 1'b0, 1, 1'b1, 100, 0, 0);
    idle(1);
    send_line(2, 1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
    idle(1);
    send_line(2, 1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
    idle(1);
    fill(8'd1); px_buf[15] = 8'd100;
    send_line(2, 1'b1, 1'b0, 1, 1'b1, 100, 0, 0);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
